t5_fetch: RTL and testbench
===========================

Name: t5_fetch

Overview:
Instruction fetch stage of the 4-hart barrel RV32 core, directly upstream of the decode stage. Holds one word-aligned PC per hart and issues one fetch per slot in strict round-robin hart order (0,1,2,3,0,...). It presents fpc, with the hart ID in fpc[1:0], alongside the returned instruction word idat. Taken branches and jumps resolved downstream are written back through a redirect port.

Parameters:
XLEN, 32, datapath and PC width.
RESET_VEC, 32'h00000000, reset PC for every hart. Bits [1:0] are ignored.

Ports:
sclk  input  1  clock, rising edge.
srst  input  1  synchronous active-high reset.
sena  input  1  global pipeline advance enable.
hena  input  4  per-hart run enable. Bit n enables hart n.
iack  input  1  imem acknowledge. idat is valid in the cycle iack=1.
idat  input  XLEN  instruction word. Passed through to decode, not registered here.
bra   input  1  redirect strobe from execute.
bpc   input  XLEN  redirect target. bpc[1:0] is the target hart; bpc[XLEN-1:2] is the new word PC.
iadr  output  XLEN  imem address, {fpc[XLEN-1:2],2'b00}.
istb  output  1  imem request strobe.
fpc   output  XLEN  PC of the current slot, {word PC, hart ID}.
fhit  output  1  istb & iack. The instruction on idat is valid for slot fpc.

Behaviour:
- Clock is sclk. Reset srst is synchronous and active-high.
- State:
  - PC file pcr[0..3], each XLEN-2 bits.
  - Slot register fpc, with the hart ID in fpc[1:0].
- Reset values:
  - pcr[n] = RESET_VEC[XLEN-1:2] for every n.
  - fpc = {RESET_VEC[XLEN-1:2], 2'b00}.
  - istb = 0 while srst is high.
- Combinational outputs:
  - istb = hena[fpc[1:0]] & !srst.
  - iadr = {fpc[XLEN-1:2], 2'b00}.
  - fhit = istb & iack.
- Request hold: iadr and istb stay stable until the slot retires.
- Slot retirement condition: sena & (iack | !istb). A disabled hart's slot retires after one sena cycle with no memory access, so barrel timing is preserved.
- On slot retirement:
  - Next hart nh = fpc[1:0] + 1, wrapping 3 -> 0.
  - fpc <= {pcr[nh], nh}.
  - If fhit, pcr[fpc[1:0]] <= fpc[XLEN-1:2] + 1. This is a word increment and wraps modulo 2^(XLEN-2).
  - A disabled slot does not advance its PC.
- Not retiring (sena=0, or istb=1 & iack=0): fpc holds, and no pcr write occurs except a redirect.
- Redirect, when bra=1, applies independently of sena and of stalls:
  - pcr[bpc[1:0]] <= bpc[XLEN-1:2].
  - Collision with the retiring increment to the same hart: the redirect wins.
  - Bypass: if bpc[1:0] == nh in the retiring cycle, fpc <= {bpc[XLEN-1:2], nh}.
  - A redirect to the hart whose fetch is outstanding does not alter that fetch. It updates only pcr, so the hart's next slot uses the target.
- Barrel latency:
  - A hart is revisited every 4 retirements.
  - Redirects arrive from execute 2 slots after fetch, so no squash is required.
- Reset mid-request: the request is abandoned and istb drops in the same cycle. The memory side must tolerate a dropped strobe.
- hena changes take effect on the next slot evaluation; the current slot's istb is recomputed combinationally.

Decomposition:
- Shared package: HART_W=2, NHART=4, RESET_VEC default, and the word-PC width macro shared with decode.
- Optional sub-module t5_pcfile: 4-entry PC register file with one read port (nh), one increment write and one redirect write, redirect priority and read bypass.

Test Plan:
1. Reset, hena=4'hF, iack=1, sena=1. Required:
   - fpc sequence 0x0, 0x1, 0x2, 0x3, then 0x4, 0x5, 0x6, 0x7.
   - iadr 0x0, 0x0, 0x0, 0x0, then 0x4, 0x4, 0x4, 0x4.
2. iack held low 3 cycles during the hart-1 slot. Required: fpc=0x1 and istb=1 stable for those cycles, no pcr change; rotation resumes after iack.
3. sena=0 for 2 cycles with iack=1. Required: fpc holds, fhit=1 but no retirement; after sena returns, pcr[hart] increments exactly once.
4. bra=1, bpc=0x00001002 while the hart-1 slot retires. Required:
   - Next fpc = 0x00001002 (bypass to hart 2).
   - iadr = 0x00001000.
   - Following hart-2 slot fpc = 0x00001006.
5. bra=1, bpc=0x00000803 while the hart-3 fetch is outstanding and retiring. Required: redirect wins over the increment, and hart 3's next fpc = 0x00000803.
6. hena=4'b0101. Required:
   - Slots 1 and 3 have istb=0 and fhit=0, and each retires in one cycle.
   - Hart 0 and hart 2 PCs advance by 4 per revolution.
   - Harts 1 and 3 keep RESET_VEC.

Source files
------------

// File: rtl/t5_fetch_pkg.sv
// Shared definitions for the t5 barrel fetch stage and its neighbours.
package t5_fetch_pkg;

    localparam int unsigned XLEN_DEF      = 32;
    localparam int unsigned HART_W        = 2;
    localparam int unsigned NHART         = 4;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

    // Word-PC width for a given XLEN (hart ID occupies the low bits).
    localparam int unsigned WPC_W_DEF = XLEN_DEF - HART_W;

    typedef logic [HART_W-1:0] hart_t;

endpackage

// File: rtl/t5_pcfile.sv
// Four-entry word-PC file: one read port with redirect bypass,
// one increment write and one redirect write (redirect has priority).
module t5_pcfile
    import t5_fetch_pkg::*;
#(
    parameter int unsigned      WPC_W   = WPC_W_DEF,
    parameter logic [WPC_W-1:0] RST_WPC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  hart_t            rd_idx,
    output logic [WPC_W-1:0] rd_data,
    input  logic             inc_en,
    input  hart_t            inc_idx,
    input  logic [WPC_W-1:0] inc_data,
    input  logic             rdr_en,
    input  hart_t            rdr_idx,
    input  logic [WPC_W-1:0] rdr_data
);

    logic [WPC_W-1:0] pcr [NHART];

    // PC storage; the redirect write is issued last so it overrides a same-hart increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NHART); i++) begin
                pcr[i] <= RST_WPC;
            end
        end else begin
            if (inc_en) begin
                pcr[inc_idx] <= inc_data;
            end
            if (rdr_en) begin
                pcr[rdr_idx] <= rdr_data;
            end
        end
    end

    // Read port with same-cycle redirect bypass.
    always_comb begin
        rd_data = pcr[rd_idx];
        if (rdr_en && (rdr_idx == rd_idx)) begin
            rd_data = rdr_data;
        end
    end

endmodule

// File: rtl/t5_fetch.sv
// Barrel fetch stage: one slot per hart in strict round-robin order.
module t5_fetch
    import t5_fetch_pkg::*;
#(
    parameter int unsigned     XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF)
) (
    input  logic              sclk,
    input  logic              srst,
    input  logic              sena,
    input  logic [NHART-1:0]  hena,
    input  logic              iack,
    input  logic [XLEN-1:0]   idat,
    input  logic              bra,
    input  logic [XLEN-1:0]   bpc,
    output logic [XLEN-1:0]   iadr,
    output logic              istb,
    output logic [XLEN-1:0]   fpc,
    output logic              fhit
);

    localparam int unsigned      WPC_W   = XLEN - HART_W;
    localparam logic [WPC_W-1:0] RST_WPC = RESET_VEC[XLEN-1:HART_W];

    hart_t            cur_hart;
    hart_t            nxt_hart;
    hart_t            bra_hart;
    logic [WPC_W-1:0] cur_wpc;
    logic [WPC_W-1:0] nxt_wpc;
    logic [WPC_W-1:0] inc_wpc;
    logic [WPC_W-1:0] bra_wpc;
    logic             retire;
    logic             unused_idat;

    // The instruction word goes straight to decode alongside fpc/fhit.
    assign unused_idat = ^idat;

    assign cur_hart = fpc[HART_W-1:0];
    assign cur_wpc  = fpc[XLEN-1:HART_W];
    assign nxt_hart = cur_hart + HART_W'(1);
    assign bra_hart = bpc[HART_W-1:0];
    assign bra_wpc  = bpc[XLEN-1:HART_W];
    assign inc_wpc  = cur_wpc + WPC_W'(1);

    // Request and hit are combinational so a reset drops the strobe immediately.
    assign istb   = hena[cur_hart] & ~srst;
    assign iadr   = {cur_wpc, HART_W'(0)};
    assign fhit   = istb & iack;
    assign retire = sena & (iack | ~istb);

    t5_pcfile #(
        .WPC_W   (WPC_W),
        .RST_WPC (RST_WPC)
    ) u_pcfile (
        .clk      (sclk),
        .rst      (srst),
        .rd_idx   (nxt_hart),
        .rd_data  (nxt_wpc),
        .inc_en   (retire & fhit),
        .inc_idx  (cur_hart),
        .inc_data (inc_wpc),
        .rdr_en   (bra),
        .rdr_idx  (bra_hart),
        .rdr_data (bra_wpc)
    );

    // Slot register: advance to the next hart when the current slot retires.
    always_ff @(posedge sclk) begin
        if (srst) begin
            fpc <= {RST_WPC, HART_W'(0)};
        end else if (retire) begin
            fpc <= {nxt_wpc, nxt_hart};
        end
    end

endmodule

// File: tb/tb_t5_fetch.sv
// Scoreboard bench for t5_fetch: stimulus pushes expected slot outputs,
// a monitor pops and compares whenever the DUT presents a slot.
module tb_t5_fetch;

    typedef struct {
        logic [31:0] fpc;
        logic        istb;
        logic        fhit;
    } exp_t;

    logic        clk = 1'b0;
    logic        srst;
    logic        sena;
    logic [3:0]  hena;
    logic        iack;
    logic [31:0] idat;
    logic        bra;
    logic [31:0] bpc;
    logic [31:0] iadr;
    logic        istb;
    logic [31:0] fpc;
    logic        fhit;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_slot  = 0;
    logic done    = 1'b0;
    logic prev_rst = 1'b0;

    t5_fetch dut (
        .sclk (clk),
        .srst (srst),
        .sena (sena),
        .hena (hena),
        .iack (iack),
        .idat (idat),
        .bra  (bra),
        .bpc  (bpc),
        .iadr (iadr),
        .istb (istb),
        .fpc  (fpc),
        .fhit (fhit)
    );

    always #5 clk = ~clk;

    // Drive one cycle and record what the DUT should present during it.
    task automatic cyc(input logic s, input logic [3:0] h, input logic a,
                       input logic b, input logic [31:0] bp,
                       input logic [31:0] ef, input logic ei, input logic eh);
        exp_t e;
        sena = s; hena = h; iack = a; bra = b; bpc = bp;
        idat = $urandom;
        e.fpc = ef; e.istb = ei; e.fhit = eh;
        if (ei || s) sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic rst_cycles(input int n);
        srst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        srst = 1'b0;
    endtask

    // Stimulus.
    initial begin
        srst = 1'b1; sena = 1'b0; hena = 4'hF; iack = 1'b0;
        idat = '0; bra = 1'b0; bpc = '0;
        repeat (3) @(posedge clk);
        #1;
        srst = 1'b0;

        // Free-running rotation.
        cyc(1, 4'hF, 1, 0, 0, 32'h0, 1, 1);
        cyc(1, 4'hF, 1, 0, 0, 32'h1, 1, 1);
        cyc(1, 4'hF, 1, 0, 0, 32'h2, 1, 1);
        cyc(1, 4'hF, 1, 0, 0, 32'h3, 1, 1);
        cyc(1, 4'hF, 1, 0, 0, 32'h4, 1, 1);
        cyc(1, 4'hF, 1, 0, 0, 32'h5, 1, 1);
        cyc(1, 4'hF, 1, 0, 0, 32'h6, 1, 1);
        cyc(1, 4'hF, 1, 0, 0, 32'h7, 1, 1);
        // iack stall on the hart-1 slot.
        cyc(1, 4'hF, 1, 0, 0, 32'h8, 1, 1);
        cyc(1, 4'hF, 0, 0, 0, 32'h9, 1, 0);
        cyc(1, 4'hF, 0, 0, 0, 32'h9, 1, 0);
        cyc(1, 4'hF, 0, 0, 0, 32'h9, 1, 0);
        cyc(1, 4'hF, 1, 0, 0, 32'h9, 1, 1);
        cyc(1, 4'hF, 1, 0, 0, 32'hA, 1, 1);
        cyc(1, 4'hF, 1, 0, 0, 32'hB, 1, 1);
        // sena low with iack high: hold, then a single retirement.
        cyc(0, 4'hF, 1, 0, 0, 32'hC, 1, 1);
        cyc(0, 4'hF, 1, 0, 0, 32'hC, 1, 1);
        cyc(1, 4'hF, 1, 0, 0, 32'hC, 1, 1);
        // Redirect to hart 2 while hart 1 retires: bypass.
        cyc(1, 4'hF, 1, 1, 32'h0000_1002, 32'hD, 1, 1);
        cyc(1, 4'hF, 1, 0, 0, 32'h0000_1002, 1, 1);
        // Redirect to hart 3 on its own retiring slot: redirect wins.
        cyc(1, 4'hF, 1, 1, 32'h0000_0803, 32'hF, 1, 1);
        cyc(1, 4'hF, 1, 0, 0, 32'h10, 1, 1);
        cyc(1, 4'hF, 1, 0, 0, 32'h11, 1, 1);
        cyc(1, 4'hF, 1, 0, 0, 32'h0000_1006, 1, 1);
        cyc(1, 4'hF, 1, 0, 0, 32'h0000_0803, 1, 1);
        // Stall, then reset mid-request.
        cyc(1, 4'hF, 0, 0, 0, 32'h14, 1, 0);
        iack = 1'b0;
        rst_cycles(2);
        // Harts 1 and 3 disabled.
        cyc(1, 4'h5, 1, 0, 0, 32'h0, 1, 1);
        cyc(1, 4'h5, 0, 0, 0, 32'h1, 0, 0);
        cyc(1, 4'h5, 1, 0, 0, 32'h2, 1, 1);
        cyc(1, 4'h5, 0, 0, 0, 32'h3, 0, 0);
        cyc(1, 4'h5, 1, 0, 0, 32'h4, 1, 1);
        cyc(1, 4'h5, 1, 0, 0, 32'h1, 0, 0);
        cyc(1, 4'h5, 1, 0, 0, 32'h6, 1, 1);
        cyc(1, 4'h5, 1, 0, 0, 32'h3, 0, 0);
        cyc(1, 4'h5, 1, 0, 0, 32'h8, 1, 1);
        done = 1'b1;
    end

    // Monitor: compare on every presented slot; check reset behaviour.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) break;
            if (srst) begin
                n_tests++;
                if (istb !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_istb: istb=%b, want 0", istb);
                end
                if (prev_rst) begin
                    n_tests++;
                    if (fpc !== 32'h0) begin
                        n_fail++;
                        $display("FAIL reset_fpc: fpc=%h, want 00000000", fpc);
                    end
                end
            end else if (istb || sena) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_slot: fpc=%h istb=%b, no expectation queued", fpc, istb);
                end else begin
                    e = sb.pop_front();
                    if (fpc !== e.fpc || istb !== e.istb || fhit !== e.fhit ||
                        iadr !== {e.fpc[31:2], 2'b00}) begin
                        n_fail++;
                        $display("FAIL slot%0d: fpc=%h istb=%b fhit=%b iadr=%h, want fpc=%h istb=%b fhit=%b iadr=%h",
                                 n_slot, fpc, istb, fhit, iadr, e.fpc, e.istb, e.fhit,
                                 {e.fpc[31:2], 2'b00});
                    end
                end
                n_slot++;
            end
            prev_rst = srst;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d expectations not presented, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end

endmodule
